// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter front end.
//   - mux_sel field codes, also used by tx_mux
//   - transmit FSM state type
package uart_tx_pkg;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator.
//   data     in  WIDTH  word to protect
//   par_typ  in  1      0 = even, 1 = odd
//   par_bit  out 1      parity bit for the word
module uart_tx_parity #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    // Odd parity is the inverted even parity (XNOR reduction).
    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter control and datapath front end. One clk cycle is one bit period.
//   clk         in  1      TX bit clock
//   rst         in  1      asynchronous active-low reset
//   P_DATA      in  WIDTH  word to send, sampled on acceptance
//   Data_Valid  in  1      request, honoured only in idle
//   PAR_EN      in  1      insert parity bit after data
//   PAR_TYP     in  1      0 = even, 1 = odd parity
//   mux_sel     out 2      frame-field select for tx_mux
//   ser_data    out 1      current data bit, LSB first
//   par_bit     out 1      parity of the latched word
//   busy        out 1      high from start bit through stop bit
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [1:0]       mux_sel,
    output logic             ser_data,
    output logic             par_bit,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    tx_state_e        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  cnt_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic             par_calc;

    uart_tx_parity #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    // Parity type needs no storage of its own: it is folded into par_bit_q at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Data_Valid) begin
                        shreg_q   <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= par_calc;
                        cnt_q     <= '0;
                        state_q   <= StStart;
                    end
                end
                StStart: state_q <= StData;
                StData: begin
                    shreg_q <= shreg_q >> 1;
                    cnt_q   <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q <= par_en_q ? StParity : StStop;
                    end
                end
                StParity: state_q <= StStop;
                StStop:   state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Shift register bit 0 is a flop, so ser_data carries no combinational logic.
    assign ser_data = shreg_q[0];
    assign par_bit  = par_bit_q;

    always_comb begin
        mux_sel = MUX_STOP;
        busy    = 1'b1;
        unique case (state_q)
            StIdle:   begin mux_sel = MUX_STOP; busy = 1'b0; end
            StStart:  mux_sel = MUX_START;
            StData:   mux_sel = MUX_DATA;
            StParity: mux_sel = MUX_PAR;
            StStop:   mux_sel = MUX_STOP;
            default:  begin mux_sel = MUX_STOP; busy = 1'b0; end
        endcase
    end

endmodule
